// File: rtl/cmach_pkg.sv
// Shared coffee-machine types: order encoding, field limits and scheduler states.
package cmach_pkg;

    localparam int ORDER_W = 6;
    localparam int TYPE_W  = 3;
    localparam int SIZE_W  = 2;

    localparam logic [TYPE_W-1:0] TYPE_MAX = 3'd4;
    localparam logic [SIZE_W-1:0] SIZE_MAX = 2'd2;

    typedef enum logic [TYPE_W-1:0] {
        RCP_ESPRESSO,
        RCP_AMERICANO,
        RCP_LATTE,
        RCP_CAPPUCCINO,
        RCP_MOCHA
    } recipe_e;

    // Type is kept as raw bits so out-of-range codes from a port stay representable.
    typedef struct packed {
        logic              flavor;
        logic [TYPE_W-1:0] btype;
        logic [SIZE_W-1:0] size;
    } order_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2,
        ST_HOLD  = 2'd3
    } sched_state_e;

    function automatic logic order_ok(input order_t o);
        return (o.btype <= TYPE_MAX) && (o.size <= SIZE_MAX);
    endfunction

endpackage

// File: rtl/brew_order_scheduler_if.sv
// Order-port handshakes plus brewer control, shared by the scheduler and its environment.
interface brew_order_scheduler_if;
    import cmach_pkg::*;

    logic               req0_valid;
    logic [ORDER_W-1:0] req0_order;
    logic               req0_ready;
    logic               req1_valid;
    logic [ORDER_W-1:0] req1_order;
    logic               req1_ready;
    logic               brew_start;
    logic [ORDER_W-1:0] brew_order;
    logic               brew_busy;
    logic               brew_done;
    logic               brew_error;

    modport slave (
        input  req0_valid, req0_order, output req0_ready,
        input  req1_valid, req1_order, output req1_ready,
        output brew_start, brew_order,
        input  brew_busy, brew_done, brew_error
    );

    modport master (
        output req0_valid, req0_order, input req0_ready,
        output req1_valid, req1_order, input req1_ready,
        input  brew_start, brew_order,
        output brew_busy, brew_done, brew_error
    );

endinterface

// File: rtl/brew_order_scheduler_order_fifo.sv
// Power-of-two order queue; the head is visible combinationally and reads as 0 when empty.
module order_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 6,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // NOTE: storage has no reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/brew_order_scheduler.sv
// Two-port round-robin order intake feeding a queue, plus the issue/run/hold brewer FSM.
module brew_order_scheduler
    import cmach_pkg::*;
#(
    parameter int QDEPTH    = 4,
    parameter int MAX_RETRY = 2,
    parameter int ACK_TO    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    brew_order_scheduler_if.slave bus,
    output logic [3:0]            q_count,
    output logic [1:0]            sched_state,
    output logic                  bad_order,
    output logic                  retry_fail
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int TW = $clog2(ACK_TO + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    sched_state_e        r_state;
    logic                r_brew_start;
    logic                r_retry_fail;
    logic                r_bad_order;
    logic                r_last_req1;
    logic                r_ready_en;
    logic                r_acked;
    logic [TW-1:0]       r_ack_cnt;
    logic [RW-1:0]       r_retry_cnt;

    logic                w_full;
    logic                w_empty;
    logic [CW-1:0]       w_count;
    logic [ORDER_W-1:0]  w_head;
    logic                w_open;
    logic                w_xfer0;
    logic                w_xfer1;
    order_t              w_in_order;
    logic                w_push;
    logic                w_pop;

    // r_last_req1 set means req1 won last, so req0 is favoured next.
    assign w_open         = r_ready_en && !w_full;
    assign bus.req0_ready = w_open && bus.req0_valid && (!bus.req1_valid || r_last_req1);
    assign bus.req1_ready = w_open && bus.req1_valid && (!bus.req0_valid || !r_last_req1);
    assign w_xfer0        = bus.req0_valid && bus.req0_ready;
    assign w_xfer1        = bus.req1_valid && bus.req1_ready;
    assign w_in_order     = w_xfer1 ? order_t'(bus.req1_order) : order_t'(bus.req0_order);
    assign w_push         = (w_xfer0 || w_xfer1) && order_ok(w_in_order);

    // NOTE: a default before the case keeps this purely combinational (no latch).
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            ST_RUN:  w_pop = bus.brew_done && !bus.brew_error;
            ST_HOLD: w_pop = !bus.brew_error && (r_retry_cnt >= RW'(MAX_RETRY));
            default: w_pop = 1'b0;
        endcase
    end

    order_fifo #(.DEPTH(QDEPTH), .WIDTH(ORDER_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_in_order),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready_en  <= 1'b0;
            r_last_req1 <= 1'b1;
            r_bad_order <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_xfer0)      r_last_req1 <= 1'b0;
            else if (w_xfer1) r_last_req1 <= 1'b1;
            if ((w_xfer0 || w_xfer1) && !order_ok(w_in_order)) r_bad_order <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_brew_start <= 1'b0;
            r_retry_fail <= 1'b0;
            r_acked      <= 1'b0;
            r_ack_cnt    <= '0;
            r_retry_cnt  <= '0;
        end else begin
            r_brew_start <= 1'b0;
            r_retry_fail <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty && !bus.brew_error) begin
                        r_state      <= ST_ISSUE;
                        r_brew_start <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_ack_cnt <= '0;
                    r_acked   <= 1'b0;
                    r_state   <= ST_RUN;
                end
                ST_RUN: begin
                    // Error outranks a simultaneous done; timeout is disarmed once busy is seen.
                    if (bus.brew_error) begin
                        r_state <= ST_HOLD;
                    end else if (bus.brew_done) begin
                        r_retry_cnt <= '0;
                        r_state     <= ST_IDLE;
                    end else if (bus.brew_busy) begin
                        r_acked <= 1'b1;
                    end else if (!r_acked) begin
                        if (r_ack_cnt == TW'(ACK_TO - 1)) r_state <= ST_HOLD;
                        else                               r_ack_cnt <= r_ack_cnt + TW'(1);
                    end
                end
                ST_HOLD: begin
                    if (!bus.brew_error) begin
                        if (r_retry_cnt >= RW'(MAX_RETRY)) begin
                            r_retry_cnt  <= '0;
                            r_retry_fail <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_retry_cnt  <= r_retry_cnt + RW'(1);
                            r_brew_start <= 1'b1;
                            r_state      <= ST_ISSUE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.brew_start = r_brew_start;
    assign bus.brew_order = w_head;
    assign q_count        = 4'(w_count);
    assign sched_state    = r_state;
    assign bad_order      = r_bad_order;
    assign retry_fail     = r_retry_fail;

endmodule

// File: doc/brew_order_scheduler.md
BREW_ORDER_SCHEDULER -- requirements
Module: brew_order_scheduler

Interface
REQ-001 Parameter QDEPTH, default 4, order queue depth in entries (power of 2, 2..8).
REQ-002 Parameter MAX_RETRY, default 2, number of re-issues allowed after a brew error.
REQ-003 Parameter ACK_TO, default 16, cycles allowed from brew_start to brew_busy.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-low.
REQ-006 req0_valid/req0_order/req0_ready  in/in/out  1/6/1  panel order port; order = {flavor, type[2:0], size[1:0]}.
REQ-007 req1_valid/req1_order/req1_ready  in/in/out  1/6/1  remote order port, same encoding.
REQ-008 brew_start  out  1  one-cycle pulse launching the head order.
REQ-009 brew_order  out  6  head order; stable while sched_state != IDLE.
REQ-010 brew_busy, brew_done, brew_error  in  1 each  brewer busy (level), completion (pulse) and fault (level).
REQ-011 q_count  out  4  current queue occupancy.
REQ-012 sched_state  out  2  0=IDLE, 1=ISSUE, 2=RUN, 3=HOLD.
REQ-013 bad_order  out  1  sticky flag for a dropped invalid order; cleared only by reset.
REQ-014 retry_fail  out  1  one-cycle pulse when an order is abandoned.

Function
REQ-015 A transfer SHALL occur on a port when valid and ready are both high at the clock edge; at most one enqueue per cycle.
REQ-016 Both readys SHALL be low when q_count == QDEPTH.
REQ-017 If exactly one port is valid and the queue is not full, only that port's ready SHALL be high.
REQ-018 If both ports are valid, ready SHALL go only to the port not granted last (round-robin); the pointer SHALL update on each transfer and SHALL reset to favour req0.
REQ-019 An accepted order with type > 4 or size > 2 SHALL be discarded (not queued) and SHALL set bad_order.
REQ-020 A simultaneous enqueue and pop SHALL leave q_count unchanged; FIFO pointers SHALL wrap modulo QDEPTH.
REQ-021 IDLE -> ISSUE when q_count > 0 and brew_error == 0.
REQ-022 ISSUE SHALL assert brew_start for exactly one cycle, clear the ACK timer, then go to RUN.
REQ-023 In RUN, brew_done SHALL pop the head, clear the retry count and return to IDLE (the next issue is at least 2 cycles after done).
REQ-024 In RUN, brew_error high, or ACK_TO cycles elapsing without brew_busy after the start, SHALL go to HOLD.
REQ-025 HOLD SHALL wait for brew_error == 0, then increment the retry count:
  - count <= MAX_RETRY -> ISSUE with the same head;
  - otherwise pop the head, pulse retry_fail and go to IDLE.
REQ-026 If brew_done and brew_error occur in the same cycle, brew_error SHALL take priority.
REQ-027 The head SHALL NOT be popped at issue, only at completion or abandonment.
REQ-028 brew_order SHALL equal the FIFO head combinationally; it is 0 when the queue is empty.

Reset
REQ-029 On asserted rst, all of the following SHALL clear asynchronously:
  - q_count = 0, sched_state = IDLE, brew_start = 0;
  - bad_order = 0, retry_fail = 0, retry count = 0, ACK timer = 0;
  - FIFO pointers = 0, round-robin pointer favouring req0.
REQ-030 Reset mid-RUN SHALL discard all queued orders, with no brew_start on release.
REQ-031 Readys SHALL be low while in reset and may rise the first cycle after release.

Structure
REQ-032 The order encoding, field widths, the valid limits (type 4, size 2) and the sched_state enum SHALL live in the shared cmach package beside the recipe type.
REQ-033 The queue SHALL be one sub-module, order_fifo (parameterised depth and width, with push, pop, full, empty and count); arbitration and the FSM stay in the top.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
  - Single order: req0 sends 6'b0_010_01; brewer busy 3 cycles then done -> one brew_start, brew_order = 6'b0_010_01, q_count 1 -> 0, IDLE.
  - Contention: req0 and req1 valid together for 4 cycles -> grants alternate 0,1,0,1; queue full at 4; both readys low afterwards.
  - Invalid order: req1 sends type 5 -> q_count unchanged, bad_order = 1 and stays 1.
  - Retry: brew_error pulses in RUN three times (MAX_RETRY = 2) -> 3 brew_starts, then retry_fail pulse and head popped.
  - ACK timeout: brew_busy never rises -> HOLD entered at start + 16 cycles, reissue follows.
  - Reset in RUN with 3 queued -> q_count = 0, IDLE, no brew_start after release.
